// File: rtl/demux_route_ctrl_16b_pkg.sv
// Shared encodings for the 16-bit demux routing controller.
package demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_EXPL = 1'b1;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  localparam int DATA_W = 16;

endpackage

// File: rtl/demux_route_ctrl_16b_demux.sv
// 16-bit 1:2 demultiplexer: the selected lane carries the word, the other lane carries zero.
module demux1_2_16b
  import demux_pkg::*;
(
  input  logic [DATA_W-1:0] i_X,
  input  logic              i_Sel,
  output logic [DATA_W-1:0] o_X0,
  output logic [DATA_W-1:0] o_X1
);

  always_comb begin
    o_X0 = '0;
    o_X1 = '0;
    if (i_Sel == LANE0) begin
      o_X0 = i_X;
    end else begin
      o_X1 = i_X;
    end
  end

endmodule

// File: rtl/demux_route_ctrl_16b.sv
// Valid/ready sequencing controller: one-deep staging register steered to one of two lanes,
// by burst round-robin or explicit per-word destination, with per-lane delivery counters.
module demux_route_ctrl_16b
  import demux_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Mode,
  input  logic [DATA_W-1:0] i_Data,
  input  logic              i_Dest,
  input  logic              i_Valid,
  output logic              o_Ready,
  output logic [DATA_W-1:0] o_X0,
  output logic              o_Valid0,
  input  logic              i_Ready0,
  output logic [DATA_W-1:0] o_X1,
  output logic              o_Valid1,
  input  logic              i_Ready1,
  output logic [CNT_W-1:0]  o_Cnt0,
  output logic [CNT_W-1:0]  o_Cnt1
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [7:0]        burst_q, burst_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              rdy_en_q;

  logic              full;
  logic              deliver;
  logic              ready;
  logic              accept;
  logic [7:0]        burst_inc;
  logic [DATA_W-1:0] stage_x;

  always_comb begin
    full      = (state_q == ST_FULL);
    deliver   = full && ((sel_q == LANE0) ? i_Ready0 : i_Ready1);
    // rdy_en_q keeps ready low through reset and for the release cycle itself
    ready     = rdy_en_q && (!full || deliver);
    accept    = i_Valid && ready;
    burst_inc = burst_q + 8'd1;

    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;

    if (accept) begin
      state_d = ST_FULL;
      data_d  = i_Data;
      if (i_Mode == MODE_EXPL) begin
        sel_d   = i_Dest;
        burst_d = '0;
      end else begin
        sel_d = rr_ptr_q;
        if (burst_inc == 8'(BURST_LEN)) begin
          burst_d  = '0;
          rr_ptr_d = ~rr_ptr_q;
        end else begin
          burst_d = burst_inc;
        end
      end
    end else if (deliver) begin
      state_d = ST_EMPTY;
    end

    if (deliver && (sel_q == LANE0)) cnt0_d = cnt0_q + CNT_W'(1);
    if (deliver && (sel_q == LANE1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q  <= ST_EMPTY;
      sel_q    <= LANE0;
      rr_ptr_q <= LANE0;
      burst_q  <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Staged word needs no reset: it is masked off the lanes whenever the stage is empty.
  always_ff @(posedge i_Clk) begin
    data_q <= data_d;
  end

  assign stage_x = full ? data_q : '0;

  demux1_2_16b u_demux (
    .i_X  (stage_x),
    .i_Sel(sel_q),
    .o_X0 (o_X0),
    .o_X1 (o_X1)
  );

  assign o_Valid0 = full && (sel_q == LANE0);
  assign o_Valid1 = full && (sel_q == LANE1);
  assign o_Ready  = ready;
  assign o_Cnt0   = cnt0_q;
  assign o_Cnt1   = cnt1_q;

endmodule

// File: tb/tb_demux_route_ctrl_16b.sv
// Directed bench for demux_route_ctrl_16b (BURST_LEN=4, CNT_W=4 so lane counters wrap quickly).
module tb_demux_route_ctrl_16b;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic [15:0] data;
  logic        dest;
  logic        valid;
  logic        ready;
  logic [15:0] x0, x1;
  logic        valid0, valid1;
  logic        ready0, ready1;
  logic [3:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_err    = 0;

  demux_route_ctrl_16b #(.BURST_LEN(4), .CNT_W(4)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .i_Mode  (mode),
    .i_Data  (data),
    .i_Dest  (dest),
    .i_Valid (valid),
    .o_Ready (ready),
    .o_X0    (x0),
    .o_Valid0(valid0),
    .i_Ready0(ready0),
    .o_X1    (x1),
    .o_Valid1(valid1),
    .i_Ready1(ready1),
    .o_Cnt0  (cnt0),
    .o_Cnt1  (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exactly one lane valid, carrying w; the other lane idle and zero.
  task automatic check_word(input string tag, input logic lane, input logic [15:0] w);
    check({tag, "_v0"}, 32'(valid0), 32'(lane == 1'b0));
    check({tag, "_v1"}, 32'(valid1), 32'(lane == 1'b1));
    check({tag, "_x0"}, 32'(x0), (lane == 1'b0) ? 32'(w) : 32'h0);
    check({tag, "_x1"}, 32'(x1), (lane == 1'b1) ? 32'(w) : 32'h0);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] t5_data [8] = '{16'h0101, 16'h0102, 16'h0201, 16'h0301,
                               16'h0302, 16'h0303, 16'h0304, 16'h0305};
  logic        t5_mode [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t5_dest [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        t5_lane [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n  = 1'b0;
    mode   = 1'b0;
    data   = 16'h0;
    dest   = 1'b0;
    valid  = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;

    // Reset held for 3 cycles with a word offered
    repeat (3) tick();
    check("rst_v0", 32'(valid0), 32'h0);
    check("rst_v1", 32'(valid1), 32'h0);
    check("rst_x0", 32'(x0), 32'h0);
    check("rst_x1", 32'(x1), 32'h0);
    check("rst_cnt0", 32'(cnt0), 32'h0);
    check("rst_cnt1", 32'(cnt1), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    rst_n = 1'b1;
    valid = 1'b0;
    #1;
    check("rel_ready_low", 32'(ready), 32'h0);
    tick();
    check("rel_ready_high", 32'(ready), 32'h1);

    // Round-robin stream 1..8: words 1-4 on lane 0, 5-8 on lane 1
    mode = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      valid = 1'b1;
      data  = 16'(i);
      #1;
      check("rr_ready", 32'(ready), 32'h1);
      if (i > 1) check_word("rr_word", (i - 1 > 4), 16'(i - 1));
      tick();
    end
    valid = 1'b0;
    #1;
    check_word("rr_last", 1'b1, 16'h0008);
    tick();
    check("rr_idle_v0", 32'(valid0), 32'h0);
    check("rr_idle_v1", 32'(valid1), 32'h0);
    check("rr_cnt0", 32'(cnt0), 32'h4);
    check("rr_cnt1", 32'(cnt1), 32'h4);

    // Explicit destinations
    mode  = 1'b1;
    valid = 1'b1;
    data  = 16'hAAAA;
    dest  = 1'b1;
    tick();
    data = 16'h5555;
    dest = 1'b0;
    #1;
    check_word("ex_aaaa", 1'b1, 16'hAAAA);
    tick();
    valid = 1'b0;
    #1;
    check_word("ex_5555", 1'b0, 16'h5555);
    tick();
    check("ex_cnt0", 32'(cnt0), 32'h5);
    check("ex_cnt1", 32'(cnt1), 32'h5);

    // Stall on lane 0 for 5 cycles with a further word offered
    valid = 1'b1;
    data  = 16'h1234;
    dest  = 1'b0;
    tick();
    ready0 = 1'b0;
    data   = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_ready", 32'(ready), 32'h0);
      check_word("st_hold", 1'b0, 16'h1234);
      check("st_cnt0", 32'(cnt0), 32'h5);
      tick();
    end
    ready0 = 1'b1;
    #1;
    check("st_release_ready", 32'(ready), 32'h1);
    tick();
    valid = 1'b0;
    #1;
    check_word("st_next", 1'b0, 16'hBEEF);
    check("st_cnt0_a", 32'(cnt0), 32'h6);
    tick();
    check("st_cnt0_b", 32'(cnt0), 32'h7);
    check("st_idle_v0", 32'(valid0), 32'h0);

    // Mode switch: explicit word mid-burst restarts the round-robin burst on lane 0
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      mode  = t5_mode[i];
      dest  = t5_dest[i];
      data  = t5_data[i];
      #1;
      if (i > 0) check_word("ms_word", t5_lane[i-1], t5_data[i-1]);
      tick();
    end
    valid = 1'b0;
    #1;
    check_word("ms_last", t5_lane[7], t5_data[7]);
    tick();
    check("ms_cnt0", 32'(cnt0), 32'hD);
    check("ms_cnt1", 32'(cnt1), 32'h7);

    // Mid-stream reset drops a word staged for lane 1
    mode   = 1'b1;
    dest   = 1'b1;
    data   = 16'hCAFE;
    valid  = 1'b1;
    ready1 = 1'b0;
    tick();
    valid = 1'b0;
    #1;
    check_word("mr_staged", 1'b1, 16'hCAFE);
    rst_n = 1'b0;
    tick();
    check("mr_v1", 32'(valid1), 32'h0);
    check("mr_x1", 32'(x1), 32'h0);
    check("mr_ready", 32'(ready), 32'h0);
    check("mr_cnt0", 32'(cnt0), 32'h0);
    check("mr_cnt1", 32'(cnt1), 32'h0);
    rst_n  = 1'b1;
    ready1 = 1'b1;
    tick();
    check("mr_after_v1", 32'(valid1), 32'h0);
    check("mr_after_ready", 32'(ready), 32'h1);

    // 17 deliveries on lane 1 wrap the 4-bit counter to 1
    mode = 1'b1;
    dest = 1'b1;
    for (int i = 0; i < 17; i++) begin
      valid = 1'b1;
      data  = 16'(16'h1000 + i);
      #1;
      if (i == 16) check("wr_cnt1_max", 32'(cnt1), 32'hF);
      tick();
    end
    valid = 1'b0;
    #1;
    check_word("wr_last", 1'b1, 16'h1010);
    tick();
    check("wr_cnt1", 32'(cnt1), 32'h1);
    check("wr_cnt0", 32'(cnt0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
